// File: rtl/core_pkg.sv
// core_pkg: definitions shared by the RV32 pipeline stages.
//   XLEN         - datapath width
//   ALU_*        - alu_op encodings, defined only here
//   mem_state_t  - MEM stage data-memory sequencer states
//   is_mem_op()  - true for ops that use the data-memory port
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_LW  = 4'b1000;
    localparam logic [3:0] ALU_SW  = 4'b1001;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_BUSY = 1'b1
    } mem_state_t;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == ALU_LW) || (op == ALU_SW);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: req/ack data-memory port.
//   dmem_req   - request, held until ack or abort
//   dmem_we    - 1 = store, 0 = load
//   dmem_addr  - byte address (always word aligned when req is high)
//   dmem_wdata - store data
//   dmem_rdata - load data, valid with dmem_ack
//   dmem_ack   - one-cycle completion strobe
// master: the pipeline side; slave: the memory side.
interface mem_stage_if;
    import core_pkg::*;

    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [XLEN-1:0] dmem_rdata;
    logic            dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );

endinterface

// File: rtl/mem_stage_timeout_ctr.sv
// mem_timeout_ctr: cycle counter for an outstanding data-memory request.
//   clk, reset  - clock, synchronous active-high reset
//   i_clear     - restart count at 0 (request issued)
//   i_enable    - count this cycle (waiting for ack)
//   o_expire    - count has reached TIMEOUT-1
module mem_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the RV32 pipeline, downstream of EX/MEM.
//   clk, reset            - clock, synchronous active-high reset
//   in_rd_addr/we/data    - destination register and EX result
//   in_mem_addr, in_op_2  - LW/SW byte address and store data
//   in_alu_op             - op code; LW/SW handled here
//   stall                 - combinational hold for EX/MEM and upstream
//   dmem                  - req/ack data-memory port (master side)
//   wb_rd_addr/we/data    - registered MEM/WB outputs
//   mem_err               - one-cycle pulse on misaligned access or timeout
//
// state    | meaning
// MEM_IDLE | no transfer in flight; non-mem ops pass straight to WB
// MEM_BUSY | request outstanding, waiting for ack or timeout
module mem_stage
    import core_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      in_rd_addr,
    input  logic            in_rd_we,
    input  logic [XLEN-1:0] in_rd_data,
    input  logic [XLEN-1:0] in_mem_addr,
    input  logic [3:0]      in_alu_op,
    input  logic [XLEN-1:0] in_op_2,
    output logic            stall,
    mem_stage_if.master     dmem,
    output logic [4:0]      wb_rd_addr,
    output logic            wb_rd_we,
    output logic [XLEN-1:0] wb_rd_data,
    output logic            mem_err
);

    mem_state_t      r_state;
    logic            r_dmem_req;
    logic            r_dmem_we;
    logic [XLEN-1:0] r_dmem_addr;
    logic [XLEN-1:0] r_dmem_wdata;
    logic [4:0]      r_ld_rd;
    logic [4:0]      r_wb_rd_addr;
    logic            r_wb_rd_we;
    logic [XLEN-1:0] r_wb_rd_data;
    logic            r_mem_err;

    logic w_is_mem;
    logic w_misaligned;
    logic w_issue;
    logic w_busy;
    logic w_wait;
    logic w_expire;

    assign w_is_mem     = is_mem_op(in_alu_op);
    assign w_misaligned = |in_mem_addr[1:0];
    assign w_busy       = (r_state == MEM_BUSY);
    assign w_issue      = !w_busy && w_is_mem && !w_misaligned;
    assign w_wait       = w_busy && !dmem.dmem_ack;

    // The last waiting cycle releases the stall so EX/MEM advances on the abort edge.
    assign stall = w_issue || (w_wait && !w_expire);

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_issue),
        .i_enable (w_wait),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= MEM_IDLE;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_ld_rd      <= '0;
            r_wb_rd_addr <= '0;
            r_wb_rd_we   <= 1'b0;
            r_wb_rd_data <= '0;
            r_mem_err    <= 1'b0;
        end else begin
            r_mem_err <= 1'b0;
            case (r_state)
                MEM_IDLE: begin
                    if (!w_is_mem) begin
                        r_wb_rd_addr <= in_rd_addr;
                        r_wb_rd_we   <= in_rd_we;
                        r_wb_rd_data <= in_rd_data;
                    end else begin
                        r_wb_rd_we <= 1'b0;
                        if (w_misaligned) begin
                            r_mem_err <= 1'b1;
                        end else begin
                            r_dmem_req   <= 1'b1;
                            r_dmem_we    <= (in_alu_op == ALU_SW);
                            r_dmem_addr  <= in_mem_addr;
                            r_dmem_wdata <= in_op_2;
                            r_ld_rd      <= in_rd_addr;
                            r_state      <= MEM_BUSY;
                        end
                    end
                end
                MEM_BUSY: begin
                    r_wb_rd_we <= 1'b0;
                    // Ack takes priority over an expiring timeout on the same cycle.
                    if (dmem.dmem_ack) begin
                        r_dmem_req <= 1'b0;
                        r_state    <= MEM_IDLE;
                        if (!r_dmem_we) begin
                            r_wb_rd_addr <= r_ld_rd;
                            r_wb_rd_we   <= 1'b1;
                            r_wb_rd_data <= dmem.dmem_rdata;
                        end
                    end else if (w_expire) begin
                        r_dmem_req <= 1'b0;
                        r_mem_err  <= 1'b1;
                        r_state    <= MEM_IDLE;
                    end
                end
            endcase
        end
    end

    assign dmem.dmem_req   = r_dmem_req;
    assign dmem.dmem_we    = r_dmem_we;
    assign dmem.dmem_addr  = r_dmem_addr;
    assign dmem.dmem_wdata = r_dmem_wdata;
    assign wb_rd_addr      = r_wb_rd_addr;
    assign wb_rd_we        = r_wb_rd_we;
    assign wb_rd_data      = r_wb_rd_data;
    assign mem_err         = r_mem_err;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage.
// An instruction stream (directed items first, then random) is laid out on a
// cycle timeline; each instruction's expected per-cycle outputs are derived
// from its kind and ack delay, then checked against the DUT every cycle.
module tb_mem_stage;
    import core_pkg::*;

    localparam int TO   = 16;
    localparam int MAXC = 3000;
    localparam int AL   = MAXC + 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  in_rd_addr = '0;
    logic        in_rd_we = 1'b0;
    logic [31:0] in_rd_data = '0;
    logic [31:0] in_mem_addr = '0;
    logic [3:0]  in_alu_op = ALU_ADD;
    logic [31:0] in_op_2 = '0;
    logic        stall;
    logic [4:0]  wb_rd_addr;
    logic        wb_rd_we;
    logic [31:0] wb_rd_data;
    logic        mem_err;

    mem_stage_if dmem ();

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_rd_addr  (in_rd_addr),
        .in_rd_we    (in_rd_we),
        .in_rd_data  (in_rd_data),
        .in_mem_addr (in_mem_addr),
        .in_alu_op   (in_alu_op),
        .in_op_2     (in_op_2),
        .stall       (stall),
        .dmem        (dmem),
        .wb_rd_addr  (wb_rd_addr),
        .wb_rd_we    (wb_rd_we),
        .wb_rd_data  (wb_rd_data),
        .mem_err     (mem_err)
    );

    always #5 clk = ~clk;

    // per-cycle stimulus
    logic [3:0]  c_op    [AL];
    logic [4:0]  c_rd    [AL];
    logic        c_rdwe  [AL];
    logic [31:0] c_rdd   [AL];
    logic [31:0] c_addr  [AL];
    logic [31:0] c_op2   [AL];
    logic        c_ack   [AL];
    logic [31:0] c_rdata [AL];
    // per-cycle expectations
    logic        e_stall [AL];
    logic        e_req   [AL];
    logic        e_dwe   [AL];
    logic [31:0] e_daddr [AL];
    logic [31:0] e_dwd   [AL];
    logic        e_wbwe  [AL];
    logic [4:0]  e_wba   [AL];
    logic [31:0] e_wbd   [AL];
    logic        e_err   [AL];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, expv);
        end
    endtask

    // Lays out one instruction starting at IDLE cycle t; d = ack delay in
    // BUSY cycles (d >= TO means the ack never comes). Returns next start cycle.
    task automatic add_instr(input int t, input logic [3:0] op, input logic [4:0] rd,
                             input logic rdwe, input logic [31:0] rdd,
                             input logic [31:0] addr, input logic [31:0] op2,
                             input int d, input logic [31:0] rdat, output int nt);
        int len;
        int busy;
        bit mem;
        mem = (op == ALU_LW) || (op == ALU_SW);
        c_ack[t]   = ($urandom_range(0, 3) == 0);
        c_rdata[t] = $urandom;
        if (!mem) begin
            len = 1;
            e_wbwe[t+1] = rdwe;
            e_wba[t+1]  = rd;
            e_wbd[t+1]  = rdd;
        end else if (addr[1:0] != 2'b00) begin
            len = 1;
            e_err[t+1] = 1'b1;
        end else begin
            busy = (d < TO) ? d + 1 : TO;
            e_stall[t] = 1'b1;
            for (int k = 0; k < busy; k++) begin
                e_req[t+1+k]   = 1'b1;
                e_dwe[t+1+k]   = (op == ALU_SW);
                e_daddr[t+1+k] = addr;
                e_dwd[t+1+k]   = op2;
                e_stall[t+1+k] = (k < busy - 1);
                c_ack[t+1+k]   = (d < TO) && (k == d);
                c_rdata[t+1+k] = ((d < TO) && (k == d)) ? rdat : $urandom;
            end
            if (d < TO) begin
                if (op == ALU_LW) begin
                    e_wbwe[t+1+busy] = 1'b1;
                    e_wba[t+1+busy]  = rd;
                    e_wbd[t+1+busy]  = rdat;
                end
            end else begin
                e_err[t+1+busy] = 1'b1;
            end
            len = 1 + busy;
        end
        for (int i = t; i < t + len; i++) begin
            c_op[i] = op; c_rd[i] = rd; c_rdwe[i] = rdwe; c_rdd[i] = rdd;
            c_addr[i] = addr; c_op2[i] = op2;
        end
        nt = t + len;
    endtask

    task automatic build_stream();
        int t;
        int d;
        int kind;
        logic [3:0]  op;
        logic [31:0] a;
        for (int i = 0; i < AL; i++) begin
            c_op[i] = ALU_ADD; c_rd[i] = '0; c_rdwe[i] = 1'b0; c_rdd[i] = '0;
            c_addr[i] = '0; c_op2[i] = '0; c_ack[i] = 1'b0; c_rdata[i] = '0;
            e_stall[i] = 1'b0; e_req[i] = 1'b0; e_dwe[i] = 1'b0; e_daddr[i] = '0;
            e_dwd[i] = '0; e_wbwe[i] = 1'b0; e_wba[i] = '0; e_wbd[i] = '0; e_err[i] = 1'b0;
        end
        t = 0;
        add_instr(t, ALU_ADD, 5'd5, 1'b1, 32'h1234, 32'h0, 32'h0, 0, 32'h0, t);          // t=0
        add_instr(t, ALU_LW,  5'd7, 1'b1, 32'h0, 32'h100, 32'h0, 3, 32'hDEADBEEF, t);   // t=1
        add_instr(t, ALU_SW,  5'd0, 1'b0, 32'h0, 32'h200, 32'hCAFEF00D, 1, 32'h0, t);   // t=6
        add_instr(t, ALU_LW,  5'd2, 1'b1, 32'h0, 32'h102, 32'h0, 0, 32'h0, t);          // t=9
        add_instr(t, ALU_LW,  5'd3, 1'b1, 32'h0, 32'h300, 32'h0, 99, 32'h0, t);         // t=10
        add_instr(t, ALU_LW,  5'd4, 1'b1, 32'h0, 32'h304, 32'h0, TO-1, 32'h5555AAAA, t);// t=27
        while (t < MAXC - 30) begin
            kind = $urandom_range(0, 3);
            a = $urandom;
            d = $urandom_range(0, 9);
            if (d < 7)      d = $urandom_range(0, 3);
            else if (d < 9) d = $urandom_range(TO - 2, TO);
            else            d = $urandom_range(4, 12);
            if (kind == 0) begin
                op = 4'($urandom_range(0, 13));
                if (op >= 4'd8) op = op + 4'd2;
            end else begin
                op = ($urandom_range(0, 1) == 0) ? ALU_LW : ALU_SW;
                if (kind == 3) a[1:0] = 2'($urandom_range(1, 3));
                else           a[1:0] = 2'b00;
            end
            add_instr(t, op, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                      $urandom, a, $urandom, d, $urandom, t);
        end
        while (t < MAXC)
            add_instr(t, ALU_ADD, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 32'h0, t);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("stall",   32'(stall),        32'(e_stall[cyc]));
            chk("req",     32'(dmem.dmem_req), 32'(e_req[cyc]));
            chk("mem_err", 32'(mem_err),      32'(e_err[cyc]));
            chk("wb_we",   32'(wb_rd_we),     32'(e_wbwe[cyc]));
            if (e_req[cyc]) begin
                chk("dmem_we",    32'(dmem.dmem_we), 32'(e_dwe[cyc]));
                chk("dmem_addr",  dmem.dmem_addr,    e_daddr[cyc]);
                chk("dmem_wdata", dmem.dmem_wdata,   e_dwd[cyc]);
            end
            if (e_wbwe[cyc]) begin
                chk("wb_addr", 32'(wb_rd_addr), 32'(e_wba[cyc]));
                chk("wb_data", wb_rd_data,      e_wbd[cyc]);
            end
            // literal pins on the directed prefix
            case (cyc)
                1:  begin chk("pin_add_addr", 32'(wb_rd_addr), 32'd5);
                          chk("pin_add_data", wb_rd_data, 32'h1234); end
                4:  chk("pin_lw_stall4", 32'(stall), 32'd1);
                5:  chk("pin_lw_stall_ack", 32'(stall), 32'd0);
                6:  begin chk("pin_lw_wb", 32'(wb_rd_we), 32'd1);
                          chk("pin_lw_data", wb_rd_data, 32'hDEADBEEF);
                          chk("pin_lw_rd", 32'(wb_rd_addr), 32'd7); end
                8:  begin chk("pin_sw_we", 32'(dmem.dmem_we), 32'd1);
                          chk("pin_sw_wdata", dmem.dmem_wdata, 32'hCAFEF00D); end
                10: begin chk("pin_mis_err", 32'(mem_err), 32'd1);
                          chk("pin_mis_req", 32'(dmem.dmem_req), 32'd0); end
                26: begin chk("pin_to_req16", 32'(dmem.dmem_req), 32'd1);
                          chk("pin_to_stall", 32'(stall), 32'd0); end
                27: begin chk("pin_to_err", 32'(mem_err), 32'd1);
                          chk("pin_to_req_off", 32'(dmem.dmem_req), 32'd0); end
                44: begin chk("pin_late_ack_we", 32'(wb_rd_we), 32'd1);
                          chk("pin_late_ack_err", 32'(mem_err), 32'd0);
                          chk("pin_late_ack_data", wb_rd_data, 32'h5555AAAA); end
                default: ;
            endcase
        end
    end

    initial begin
        dmem.dmem_ack   = 1'b0;
        dmem.dmem_rdata = '0;
        build_stream();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req",   32'(dmem.dmem_req), 32'd0);
        chk("rst_dwe",   32'(dmem.dmem_we), 32'd0);
        chk("rst_daddr", dmem.dmem_addr, 32'd0);
        chk("rst_wdata", dmem.dmem_wdata, 32'd0);
        chk("rst_wbwe",  32'(wb_rd_we), 32'd0);
        chk("rst_wba",   32'(wb_rd_addr), 32'd0);
        chk("rst_wbd",   wb_rd_data, 32'd0);
        chk("rst_err",   32'(mem_err), 32'd0);

        for (int c = 0; c < MAXC; c++) begin
            @(posedge clk);
            #1;
            reset           = 1'b0;
            cyc             = c;
            in_alu_op       = c_op[c];
            in_rd_addr      = c_rd[c];
            in_rd_we        = c_rdwe[c];
            in_rd_data      = c_rdd[c];
            in_mem_addr     = c_addr[c];
            in_op_2         = c_op2[c];
            dmem.dmem_ack   = c_ack[c];
            dmem.dmem_rdata = c_rdata[c];
            chk_on          = 1'b1;
        end
        @(negedge clk);
        chk_on = 1'b0;

        // reset while BUSY
        @(posedge clk); #1;
        in_alu_op = ALU_LW; in_rd_addr = 5'd9; in_rd_we = 1'b1;
        in_mem_addr = 32'h400; dmem.dmem_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rb_req_busy", 32'(dmem.dmem_req), 32'd1);
        reset = 1'b1;
        in_alu_op = ALU_ADD; in_rd_we = 1'b0; in_mem_addr = 32'h0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rb_req",   32'(dmem.dmem_req), 32'd0);
        chk("rb_wbwe",  32'(wb_rd_we), 32'd0);
        chk("rb_stall", 32'(stall), 32'd0);
        chk("rb_err",   32'(mem_err), 32'd0);
        @(negedge clk);
        chk("rb_req2",  32'(dmem.dmem_req), 32'd0);
        chk("rb_err2",  32'(mem_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
